sched_link_32x8: RTL and testbench

//  Round-robin scheduler that shares one 8-bit byte link between two 32-bit word sources.

---
 rtl/sched_link_32x8_pkg.sv | 28 ++
 rtl/sched_link_32x8_if.sv | 40 ++++
 rtl/sched_link_32x8_rr_arb2.sv | 20 ++
 rtl/sched_link_32x8.sv | 168 ++++++++++++++++
 tb/tb_sched_link_32x8.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/sched_link_32x8_pkg.sv
// sched_link_32x8_pkg
//   Shared types and constants for the two-source word-to-byte link scheduler.
//   - sched_state_e   : FSM state encoding (StIdle, StSend)
//   - ByteIdx0..3     : byte-lane index constants (0 = most significant byte)
//   - Def*W           : default widths for word, byte and statistics counters
//   - bytes_per_word(): number of link bytes per word
package sched_link_32x8_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } sched_state_e;

    localparam int unsigned DefWordW = 32;
    localparam int unsigned DefByteW = 8;
    localparam int unsigned DefStatW = 8;

    localparam logic [1:0] ByteIdx0 = 2'd0;
    localparam logic [1:0] ByteIdx1 = 2'd1;
    localparam logic [1:0] ByteIdx2 = 2'd2;
    localparam logic [1:0] ByteIdx3 = 2'd3;

    function automatic int unsigned bytes_per_word(input int unsigned word_w,
                                                   input int unsigned byte_w);
        return word_w / byte_w;
    endfunction

endpackage

// File: rtl/sched_link_32x8_if.sv
// sched_link_32x8_if
//   Bundles both word-source handshakes and the byte-link outputs.
//   Modports:
//     slave  : scheduler side (sources in, readies and link out)
//     master : environment side (drives sources, observes readies and link)
//   Signals:
//     data_in0/1, valid_in0/1 : word sources
//     ready_out0/1            : combinational accepts
//     data_out_8, valid_out_8 : registered link byte
//     sel_byte_out            : registered byte index (0 = MSB)
//     src_id_out              : registered source of the current byte
//     word_done_out           : registered pulse on the last byte of a word
interface sched_link_32x8_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned BYTE_W = 8
);
    logic [WORD_W-1:0] data_in0;
    logic              valid_in0;
    logic              ready_out0;
    logic [WORD_W-1:0] data_in1;
    logic              valid_in1;
    logic              ready_out1;
    logic [BYTE_W-1:0] data_out_8;
    logic              valid_out_8;
    logic [1:0]        sel_byte_out;
    logic              src_id_out;
    logic              word_done_out;

    modport slave (
        input  data_in0, valid_in0, data_in1, valid_in1,
        output ready_out0, ready_out1, data_out_8, valid_out_8,
        output sel_byte_out, src_id_out, word_done_out
    );

    modport master (
        output data_in0, valid_in0, data_in1, valid_in1,
        input  ready_out0, ready_out1, data_out_8, valid_out_8,
        input  sel_byte_out, src_id_out, word_done_out
    );
endinterface

// File: rtl/sched_link_32x8_rr_arb2.sv
// sched_link_32x8_rr_arb2
//   Two-requester round-robin arbiter (purely combinational).
//   Ports:
//     req_i[1:0] : request per requester
//     en_i       : grants are only issued while high
//     last_i     : index of the most recently granted requester
//     gnt_o[1:0] : one-hot (or zero) grant
module sched_link_32x8_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);
    // On contention the requester that was not served last wins.
    always_comb begin
        gnt_o    = 2'b00;
        gnt_o[0] = en_i & req_i[0] & (~req_i[1] | last_i);
        gnt_o[1] = en_i & req_i[1] & (~req_i[0] | ~last_i);
    end
endmodule

// File: rtl/sched_link_32x8.sv
// sched_link_32x8
//   Round-robin scheduler sharing one byte link between two word sources. A granted
//   word is captured and sent MSB first as consecutive bytes; a new word may be
//   accepted on the last byte so words follow each other without a bubble.
//   Ports:
//     clk_4f   : byte-rate clock, all state on its rising edge
//     reset_L  : asynchronous active-low reset
//     link     : sched_link_32x8_if.slave (sources, readies, link outputs)
//     words_out0/1 : accepted-word counters, saturating (only with SCHED_STATS_EN)
//   Optional feature macro: SCHED_STATS_EN
module sched_link_32x8
    import sched_link_32x8_pkg::*;
#(
    parameter int unsigned WORD_W = DefWordW,
    parameter int unsigned BYTE_W = DefByteW,
    parameter int unsigned STAT_W = DefStatW
) (
    input  logic                 clk_4f,
    input  logic                 reset_L,
`ifdef SCHED_STATS_EN
    output logic [STAT_W-1:0]    words_out0,
    output logic [STAT_W-1:0]    words_out1,
`endif
    sched_link_32x8_if.slave     link
);
    localparam int unsigned NumBytes = bytes_per_word(WORD_W, BYTE_W);
    localparam logic [1:0]  LastIdx  = 2'(NumBytes - 1);

    sched_state_e      state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              src_q, src_d;
    logic              last_grant_q, last_grant_d;
    logic [BYTE_W-1:0] data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;
    logic [1:0]        sel_q, sel_d;
    logic              src_id_q, src_id_d;
    logic              word_done_q, word_done_d;

    logic              cap_en;
    logic [1:0]        gnt;
    logic              xfer;
    logic              xfer_src;
    logic [WORD_W-1:0] xfer_word;
    logic [1:0]        cnt_next;
    logic [WORD_W-1:0] word_shift;

    assign cap_en = (state_q == StIdle) | ((state_q == StSend) & (byte_cnt_q == LastIdx));

    sched_link_32x8_rr_arb2 u_arb (
        .req_i  ({link.valid_in1, link.valid_in0}),
        .en_i   (cap_en),
        .last_i (last_grant_q),
        .gnt_o  (gnt)
    );

    assign xfer      = |gnt;
    assign xfer_src  = gnt[1];
    assign xfer_word = gnt[1] ? link.data_in1 : link.data_in0;
    assign cnt_next  = byte_cnt_q + 2'd1;
    // Left-align the next byte so it can be taken from the top of the word.
    assign word_shift = word_q << (BYTE_W * cnt_next);

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;
        data_out_d   = '0;
        valid_out_d  = 1'b0;
        sel_d        = ByteIdx0;
        src_id_d     = src_id_q;
        word_done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (xfer) state_d = StSend;
            end
            StSend: begin
                if ((byte_cnt_q == LastIdx) && !xfer) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (xfer) begin
            // Byte 0 of the accepted word goes straight into the output register.
            word_d       = xfer_word;
            src_d        = xfer_src;
            last_grant_d = xfer_src;
            byte_cnt_d   = ByteIdx0;
            data_out_d   = xfer_word[WORD_W-1 -: BYTE_W];
            valid_out_d  = 1'b1;
            sel_d        = ByteIdx0;
            src_id_d     = xfer_src;
            word_done_d  = (LastIdx == ByteIdx0);
        end else if ((state_q == StSend) && (byte_cnt_q != LastIdx)) begin
            byte_cnt_d  = cnt_next;
            data_out_d  = word_shift[WORD_W-1 -: BYTE_W];
            valid_out_d = 1'b1;
            sel_d       = cnt_next;
            src_id_d    = src_q;
            word_done_d = (cnt_next == LastIdx);
        end else begin
            byte_cnt_d = ByteIdx0;
        end
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= StIdle;
            byte_cnt_q   <= ByteIdx0;
            word_q       <= '0;
            src_q        <= 1'b0;
            last_grant_q <= 1'b1;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            sel_q        <= ByteIdx0;
            src_id_q     <= 1'b0;
            word_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            sel_q        <= sel_d;
            src_id_q     <= src_id_d;
            word_done_q  <= word_done_d;
        end
    end

    assign link.ready_out0    = gnt[0];
    assign link.ready_out1    = gnt[1];
    assign link.data_out_8    = data_out_q;
    assign link.valid_out_8   = valid_out_q;
    assign link.sel_byte_out  = sel_q;
    assign link.src_id_out    = src_id_q;
    assign link.word_done_out = word_done_q;

`ifdef SCHED_STATS_EN
    logic [STAT_W-1:0] words0_q, words0_d;
    logic [STAT_W-1:0] words1_q, words1_d;

    always_comb begin
        words0_d = words0_q;
        words1_d = words1_q;
        if (gnt[0] && (words0_q != '1)) words0_d = words0_q + 1'b1;
        if (gnt[1] && (words1_q != '1)) words1_d = words1_q + 1'b1;
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            words0_q <= '0;
            words1_q <= '0;
        end else begin
            words0_q <= words0_d;
            words1_q <= words1_d;
        end
    end

    assign words_out0 = words0_q;
    assign words_out1 = words1_q;
`endif

endmodule

// File: tb/tb_sched_link_32x8.sv
// tb_sched_link_32x8
//   Directed bench for sched_link_32x8: single word, withdrawn request, reset mid-word,
//   first contention after reset, back-to-back alternating words and (with
//   SCHED_STATS_EN) counter saturation.
module tb_sched_link_32x8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sched_link_32x8_if #(.WORD_W(32), .BYTE_W(8)) link_if ();

`ifdef SCHED_STATS_EN
    logic [7:0] words_out0;
    logic [7:0] words_out1;
`endif

    sched_link_32x8 #(
        .WORD_W (32),
        .BYTE_W (8),
        .STAT_W (8)
    ) dut (
        .clk_4f     (clk),
        .reset_L    (rst_n),
`ifdef SCHED_STATS_EN
        .words_out0 (words_out0),
        .words_out1 (words_out1),
`endif
        .link       (link_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Packed link view: {valid, data[7:0], sel[1:0], src, done}
    function automatic logic [31:0] link_vec(input logic v, input logic [7:0] d,
                                             input logic [1:0] s, input logic src,
                                             input logic done);
        return {19'd0, v, d, s, src, done};
    endfunction

    function automatic logic [31:0] dut_link();
        return link_vec(link_if.valid_out_8, link_if.data_out_8, link_if.sel_byte_out,
                        link_if.src_id_out, link_if.word_done_out);
    endfunction

    function automatic logic [31:0] dut_ready();
        return {30'd0, link_if.ready_out1, link_if.ready_out0};
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        link_if.data_in0  = '0;
        link_if.valid_in0 = 1'b0;
        link_if.data_in1  = '0;
        link_if.valid_in1 = 1'b0;

        // Reset state
        tick;
        tick;
        check("reset_link", dut_link(), link_vec(0, 8'h00, 2'd0, 0, 0));
        check("reset_ready", dut_ready(), 32'd0);
        rst_n = 1'b1;
        tick;
        check("idle_link", dut_link(), link_vec(0, 8'h00, 2'd0, 0, 0));

        // 1. Single word from source 0
        link_if.data_in0  = 32'hA1B2C3D4;
        link_if.valid_in0 = 1'b1;
        #1;
        check("t1_ready", dut_ready(), 32'd1);
        tick;
        link_if.valid_in0 = 1'b0;
        #1;
        check("t1_b0", dut_link(), link_vec(1, 8'hA1, 2'd0, 0, 0));
        check("t1_ready_b0", dut_ready(), 32'd0);
        tick;
        check("t1_b1", dut_link(), link_vec(1, 8'hB2, 2'd1, 0, 0));
        tick;
        check("t1_b2", dut_link(), link_vec(1, 8'hC3, 2'd2, 0, 0));
        tick;
        check("t1_b3", dut_link(), link_vec(1, 8'hD4, 2'd3, 0, 1));
        tick;
        check("t1_idle", dut_link(), link_vec(0, 8'h00, 2'd0, 0, 0));

        // 4. Source 1 request withdrawn while source 0 is mid-word
        link_if.data_in0  = 32'h55667788;
        link_if.valid_in0 = 1'b1;
        tick;
        link_if.valid_in0 = 1'b0;
        link_if.data_in1  = 32'hDEADBEEF;
        link_if.valid_in1 = 1'b1;
        #1;
        check("t4_b0", dut_link(), link_vec(1, 8'h55, 2'd0, 0, 0));
        check("t4_rdy_b0", dut_ready(), 32'd0);
        tick;
        check("t4_b1", dut_link(), link_vec(1, 8'h66, 2'd1, 0, 0));
        check("t4_rdy_b1", dut_ready(), 32'd0);
        tick;
        check("t4_b2", dut_link(), link_vec(1, 8'h77, 2'd2, 0, 0));
        check("t4_rdy_b2", dut_ready(), 32'd0);
        link_if.valid_in1 = 1'b0;
        tick;
        check("t4_b3", dut_link(), link_vec(1, 8'h88, 2'd3, 0, 1));
        check("t4_rdy_b3", dut_ready(), 32'd0);
        tick;
        check("t4_idle", dut_link(), link_vec(0, 8'h00, 2'd0, 0, 0));

        // 5. Reset pulsed at sel_byte_out=1 during a source 1 word
        link_if.data_in1  = 32'h99AABBCC;
        link_if.valid_in1 = 1'b1;
        #1;
        check("t5_ready", dut_ready(), 32'd2);
        tick;
        link_if.valid_in1 = 1'b0;
        check("t5_b0", dut_link(), link_vec(1, 8'h99, 2'd0, 1, 0));
        tick;
        check("t5_b1", dut_link(), link_vec(1, 8'hAA, 2'd1, 1, 0));
        rst_n = 1'b0;
        #1;
        check("t5_async", dut_link(), link_vec(0, 8'h00, 2'd0, 0, 0));
        tick;
        check("t5_held", dut_link(), link_vec(0, 8'h00, 2'd0, 0, 0));
        rst_n = 1'b1;
        tick;
        check("t5_nostale0", dut_link(), link_vec(0, 8'h00, 2'd0, 0, 0));
        tick;
        check("t5_nostale1", dut_link(), link_vec(0, 8'h00, 2'd0, 0, 0));

        // 3 + 2. First contention after reset goes to source 0, then strict alternation
        link_if.data_in0  = 32'h11111111;
        link_if.data_in1  = 32'h22222222;
        link_if.valid_in0 = 1'b1;
        link_if.valid_in1 = 1'b1;
        #1;
        check("t3_first_grant", dut_ready(), 32'd1);
        tick;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 4; b++) begin
                logic       src;
                logic [7:0] byte_exp;
                src      = (w % 2 == 1);
                byte_exp = src ? 8'h22 : 8'h11;
                check($sformatf("t2_w%0d_b%0d", w, b), dut_link(),
                      link_vec(1, byte_exp, 2'(b), src, (b == 3)));
                if (b == 3) begin
                    check($sformatf("t2_rdy_w%0d", w), dut_ready(), src ? 32'd1 : 32'd2);
                end else begin
                    check($sformatf("t2_rdy_w%0d_b%0d", w, b), dut_ready(), 32'd0);
                end
                if ((w == 3) && (b == 3)) begin
                    link_if.valid_in0 = 1'b0;
                    link_if.valid_in1 = 1'b0;
                end
                tick;
            end
        end
        check("t2_idle", dut_link(), link_vec(0, 8'h00, 2'd0, 1, 0));

`ifdef SCHED_STATS_EN
        // 6. Source 1 counter saturates; source 0 stays at zero
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("t6_reset_w0", {24'd0, words_out0}, 32'd0);
        check("t6_reset_w1", {24'd0, words_out1}, 32'd0);
        link_if.valid_in1 = 1'b1;
        for (int i = 0; i < 1300; i++) tick;
        link_if.valid_in1 = 1'b0;
        for (int i = 0; i < 6; i++) tick;
        check("t6_w1_sat", {24'd0, words_out1}, 32'd255);
        check("t6_w0_zero", {24'd0, words_out0}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
